// File: rtl/add_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor with a valid/ready stream interface; the carry ripples one SEG-bit segment per stage.
// Optional signed-overflow output is enabled by defining ADD_PIPE_OVERFLOW_EN.
module add_pipe_nbit #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    output logic             valid_out,
    input  logic             ready_in,
`ifdef ADD_PIPE_OVERFLOW_EN
    output logic             overflow_out,
`endif
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int STAGES = WIDTH / SEG;

    // Single global enable: the whole pipeline advances or holds together.
    logic en;
    assign en        = !valid_out || ready_in;
    assign ready_out = en;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int REM  = WIDTH - gi * SEG;
        localparam int LO   = gi * SEG;
        localparam bit LAST = (gi == STAGES - 1);

        logic [REM-1:0]      a_src;
        logic [REM-1:0]      b_src;
        logic                cin;
        logic                v_src;
        logic [SEG:0]        seg_sum;
        logic [LO+SEG-1:0]   sum_d;
        logic [LO+SEG-1:0]   sum_q;
        logic                carry_q;
        logic                valid_q;
        logic                load_data;

        if (gi == 0) begin : g_in
            // B is inverted once here; the subtract carry-in becomes the stage-0 carry.
            assign a_src = a_in;
            assign b_src = b_in ^ {WIDTH{sub_in}};
            assign cin   = sub_in;
            assign v_src = valid_in;
            assign sum_d = seg_sum[SEG-1:0];
        end else begin : g_chain
            assign a_src = g_stage[gi-1].g_fwd.a_q;
            assign b_src = g_stage[gi-1].g_fwd.b_q;
            assign cin   = g_stage[gi-1].carry_q;
            assign v_src = g_stage[gi-1].valid_q;
            assign sum_d = {seg_sum[SEG-1:0], g_stage[gi-1].sum_q};
        end

        assign seg_sum = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]} + {{SEG{1'b0}}, cin};

        // The output stage only loads real results so bubbles leave sum/carry untouched.
        assign load_data = !LAST || v_src;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (en) begin
                valid_q <= v_src;
                if (load_data) begin
                    sum_q   <= sum_d;
                    carry_q <= seg_sum[SEG];
                end
            end
        end

        if (!LAST) begin : g_fwd
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] b_q;

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_src[REM-1:SEG];
                    b_q <= b_src[REM-1:SEG];
                end
            end
        end

`ifdef ADD_PIPE_OVERFLOW_EN
        if (LAST) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign ovf_d = (a_src[SEG-1] ^ b_src[SEG-1] ^ seg_sum[SEG-1]) ^ seg_sum[SEG];

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    ovf_q <= 1'b0;
                end else if (en && load_data) begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    assign valid_out = g_stage[STAGES-1].valid_q;
    assign sum_out   = g_stage[STAGES-1].sum_q;
    assign carry_out = g_stage[STAGES-1].carry_q;
`ifdef ADD_PIPE_OVERFLOW_EN
    assign overflow_out = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_add_pipe_nbit.sv
// Directed self-checking bench for add_pipe_nbit (WIDTH=16, SEG=4, four stages).
// Overflow checks are compiled in when ADD_PIPE_OVERFLOW_EN is defined.
module tb_add_pipe_nbit;

    logic        clk_in;
    logic        rst_in;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        sub_in;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] sum_out;
    logic        carry_out;
`ifdef ADD_PIPE_OVERFLOW_EN
    logic        overflow_out;
`endif

    int n_checks;
    int n_fail;

    add_pipe_nbit #(.WIDTH(16), .SEG(4)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
`ifdef ADD_PIPE_OVERFLOW_EN
        .overflow_out(overflow_out),
`endif
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Drives one op at a negedge and waits (bounded) for its result; lat=-1 on timeout.
    task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        a_in     = a;
        b_in     = b;
        sub_in   = s;
        valid_in = 1'b1;
        lat      = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
            if (valid_out === 1'b1) begin
                lat = k;
                break;
            end
        end
        $display("op a=%h b=%h sub=%0b -> sum=%h carry=%0b latency=%0d", a, b, s, sum_out, carry_out, lat);
    endtask

    task automatic test_reset;
        @(negedge clk_in);
        n_checks += 4;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        if (sum_out !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum_out); end
        if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry_out); end
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        rst_in   = 1'b0;
        ready_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_basic_add;
        int lat;
        run_single(16'h1234, 16'h4321, 1'b0, lat);
        n_checks += 3;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        if (sum_out !== 16'h5555) begin n_fail++; $display("FAIL basic_sum: got %h want 5555", sum_out); end
        if (carry_out !== 1'b0) begin n_fail++; $display("FAIL basic_carry: got %b want 0", carry_out); end
        @(negedge clk_in);
        n_checks += 2;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", valid_out); end
        if (sum_out !== 16'h5555) begin n_fail++; $display("FAIL held_sum: got %h want 5555", sum_out); end
    endtask

    task automatic test_carry_ripple;
        int lat;
        run_single(16'hFFFF, 16'h0001, 1'b0, lat);
        n_checks += 3;
        if (lat !== 4) begin n_fail++; $display("FAIL ripple_latency: got %0d want 4", lat); end
        if (sum_out !== 16'h0000) begin n_fail++; $display("FAIL ripple_sum: got %h want 0000", sum_out); end
        if (carry_out !== 1'b1) begin n_fail++; $display("FAIL ripple_carry: got %b want 1", carry_out); end
        run_single(16'h0FFF, 16'h0001, 1'b0, lat);
        n_checks += 2;
        if (sum_out !== 16'h1000) begin n_fail++; $display("FAIL ripple3_sum: got %h want 1000", sum_out); end
        if (carry_out !== 1'b0) begin n_fail++; $display("FAIL ripple3_carry: got %b want 0", carry_out); end
    endtask

    task automatic test_subtract;
        int lat;
        run_single(16'h0007, 16'h0005, 1'b1, lat);
        n_checks += 3;
        if (lat !== 4) begin n_fail++; $display("FAIL sub_latency: got %0d want 4", lat); end
        if (sum_out !== 16'h0002) begin n_fail++; $display("FAIL sub_7m5_sum: got %h want 0002", sum_out); end
        if (carry_out !== 1'b1) begin n_fail++; $display("FAIL sub_7m5_carry: got %b want 1", carry_out); end
        run_single(16'h0005, 16'h0007, 1'b1, lat);
        n_checks += 2;
        if (sum_out !== 16'hFFFE) begin n_fail++; $display("FAIL sub_5m7_sum: got %h want fffe", sum_out); end
        if (carry_out !== 1'b0) begin n_fail++; $display("FAIL sub_5m7_carry: got %b want 0", carry_out); end
        run_single(16'h8000, 16'h8000, 1'b1, lat);
        n_checks += 2;
        if (sum_out !== 16'h0000) begin n_fail++; $display("FAIL sub_eq_sum: got %h want 0000", sum_out); end
        if (carry_out !== 1'b1) begin n_fail++; $display("FAIL sub_eq_carry: got %b want 1", carry_out); end
    endtask

    task automatic test_back_to_back;
        int          tx;
        int          rx;
        logic        exp_rdy;
        logic [15:0] exp_sum;
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk_in);
            ready_in = !(cyc >= 5 && cyc <= 7);
            if (tx < 8) begin
                valid_in = 1'b1;
                a_in     = 16'(tx);
                b_in     = 16'(tx * 256);
                sub_in   = 1'b0;
            end else begin
                valid_in = 1'b0;
            end
            #1;
            exp_rdy = (cyc < 5 || cyc > 7);
            n_checks++;
            if (ready_out !== exp_rdy) begin n_fail++; $display("FAIL stream_ready cyc %0d: got %b want %b", cyc, ready_out, exp_rdy); end
            if (valid_out === 1'b1) begin
                exp_sum = 16'(rx * 257);
                n_checks += 3;
                if (rx >= 8) begin n_fail++; $display("FAIL stream_extra cyc %0d: result %0d got, only 8 sent", cyc, rx); end
                if (sum_out !== exp_sum) begin n_fail++; $display("FAIL stream_sum[%0d] cyc %0d: got %h want %h", rx, cyc, sum_out, exp_sum); end
                if (carry_out !== 1'b0) begin n_fail++; $display("FAIL stream_carry[%0d]: got %b want 0", rx, carry_out); end
                if (ready_in) begin
                    $display("stream rx %0d sum=%h", rx, sum_out);
                    rx++;
                end
            end
            if (valid_in && ready_out) tx++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        n_checks += 2;
        if (tx !== 8) begin n_fail++; $display("FAIL stream_sent: got %0d want 8", tx); end
        if (rx !== 8) begin n_fail++; $display("FAIL stream_received: got %0d want 8", rx); end
    endtask

    task automatic test_reset_mid;
        int lat;
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in     = 16'(i + 1);
            b_in     = 16'h0010;
            sub_in   = 1'b0;
            valid_in = 1'b1;
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        n_checks += 2;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", valid_out); end
        if (sum_out !== 16'h0011) begin n_fail++; $display("FAIL mid_pre_sum: got %h want 0011", sum_out); end
        #2 rst_in = 1'b1;
        #1;
        n_checks += 3;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", valid_out); end
        if (sum_out !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_sum: got %h want 0000", sum_out); end
        if (carry_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_carry: got %b want 0", carry_out); end
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            n_checks++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid cyc %0d: got %b want 0", k, valid_out); end
        end
        run_single(16'h1111, 16'h2222, 1'b0, lat);
        n_checks += 3;
        if (lat !== 4) begin n_fail++; $display("FAIL mid_after_latency: got %0d want 4", lat); end
        if (sum_out !== 16'h3333) begin n_fail++; $display("FAIL mid_after_sum: got %h want 3333", sum_out); end
        if (carry_out !== 1'b0) begin n_fail++; $display("FAIL mid_after_carry: got %b want 0", carry_out); end
    endtask

`ifdef ADD_PIPE_OVERFLOW_EN
    task automatic test_overflow;
        int lat;
        run_single(16'h7FFF, 16'h0001, 1'b0, lat);
        n_checks += 2;
        if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_pos: got %b want 1", overflow_out); end
        if (sum_out !== 16'h8000) begin n_fail++; $display("FAIL ovf_pos_sum: got %h want 8000", sum_out); end
        run_single(16'hFFFF, 16'h0001, 1'b0, lat);
        n_checks++;
        if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL ovf_wrap: got %b want 0", overflow_out); end
        run_single(16'h8000, 16'h0001, 1'b1, lat);
        n_checks += 2;
        if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sub: got %b want 1", overflow_out); end
        if (sum_out !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_sub_sum: got %h want 7fff", sum_out); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        sub_in   = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_subtract();
        test_back_to_back();
        test_reset_mid();
`ifdef ADD_PIPE_OVERFLOW_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
